mips_cpu_mem_sequencer: RTL and testbench

Sequences every Avalon-MM memory access of the multicycle MIPS core and arbitrates the single memory port between two requesters: instruction fetch and load/store data. It generates word address, byte lanes and write-data replication for byte, half and word accesses. It holds each transfer across waitrequest and returns aligned, sign- or zero-extended read data with a one-cycle done pulse. It sits between the core controller/datapath and the external memory bus.

---
 rtl/mips_cpu_pkg.sv | 20 ++
 rtl/mips_cpu_lane_align.sv | 62 ++++++
 rtl/mips_cpu_mem_sequencer.sv | 120 ++++++++++++
 tb/tb_mips_cpu_mem_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS core memory sequencer.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Little-endian lane steering: byteenable, store replication, alignment check
// and load extraction with sign/zero extension.
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] wdata_rep,
  output logic              misaligned,
  output logic [DATA_W-1:0] rdata_ext
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic s);
    return {{(DATA_W-8){s & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic s);
    return {{(DATA_W-16){s & h[15]}}, h};
  endfunction

  logic [7:0] byte_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  always_comb begin
    byteenable = BE_WORD;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    rdata_ext  = rdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        rdata_ext  = ext_byte(byte_sel, sgn);
      end
      SIZE_HALF: begin
        misaligned = addr_lo[0];
        byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = ext_half(addr_lo[1] ? rdata[31:16] : rdata[15:0], sgn);
      end
      // Word, and the reserved encoding, behave as a full-word access.
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_sequencer.sv
// Single-port Avalon-MM sequencer for the multicycle MIPS core: arbitrates
// fetch vs load/store (data wins), holds across waitrequest, pulses done.
module mips_cpu_mem_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic              data_signed,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              ifetch_done,
  output logic [DATA_W-1:0] ifetch_rdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              misaligned,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  seq_state_t        state, state_nxt;
  logic              src_data, sgn_r, we_r, mis_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;

  logic              accept, in_bus, in_resp;
  logic [1:0]        req_size, la_size, la_addr;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        la_be;
  logic [DATA_W-1:0] la_wrep, la_rext;
  logic              la_mis;

  assign accept   = (state == IDLE) && (data_req || ifetch_req);
  assign req_size = data_req ? data_size : SIZE_WORD;
  assign req_addr = data_req ? data_addr : ifetch_addr;
  assign in_bus   = (state == BUS);
  assign in_resp  = (state == RESP);

  // In IDLE the aligner screens the incoming request; afterwards it works
  // purely from the captured transfer so bus signals stay stable.
  assign la_size = (state == IDLE) ? req_size : size_r;
  assign la_addr = (state == IDLE) ? req_addr[1:0] : addr_r[1:0];

  mips_cpu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .size       (la_size),
    .addr_lo    (la_addr),
    .sgn        (sgn_r),
    .wdata      (wdata_r),
    .rdata      (rdata_r),
    .byteenable (la_be),
    .wdata_rep  (la_wrep),
    .misaligned (la_mis),
    .rdata_ext  (la_rext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src_data <= 1'b0;
      sgn_r    <= 1'b0;
      we_r     <= 1'b0;
      mis_r    <= 1'b0;
      size_r   <= 2'd0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_data <= data_req;
        sgn_r    <= data_req & data_signed;
        we_r     <= data_req & data_we;
        mis_r    <= la_mis;
        size_r   <= req_size;
        addr_r   <= req_addr;
        wdata_r  <= data_req ? data_wdata : '0;
      end
      if (in_bus && !avm_waitrequest && !we_r)
        rdata_r <= avm_readdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = la_mis ? RESP : BUS;
      BUS:     if (!avm_waitrequest) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign avm_read       = in_bus & ~we_r;
  assign avm_write      = in_bus & we_r;
  assign avm_address    = in_bus ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign avm_byteenable = in_bus ? la_be : 4'b0000;
  assign avm_writedata  = avm_write ? la_wrep : '0;

  assign ifetch_done  = in_resp & ~src_data;
  assign data_done    = in_resp & src_data;
  assign misaligned   = in_resp & mis_r;
  assign ifetch_rdata = (ifetch_done & ~mis_r) ? rdata_r : '0;
  assign data_rdata   = (data_done & ~we_r & ~mis_r) ? la_rext : '0;

endmodule

// File: tb/tb_mips_cpu_mem_sequencer.sv
// Scoreboard bench: byte-level reference memory predicts every done and bus cycle.
module tb_mips_cpu_mem_sequencer;

  logic        clk, reset;
  logic        ifetch_req, data_req, data_we, data_signed;
  logic [31:0] ifetch_addr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic        ifetch_done, data_done, misaligned, busy;
  logic [31:0] ifetch_rdata, data_rdata;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;

  mips_cpu_mem_sequencer dut (
    .clk(clk), .reset(reset),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .data_req(data_req), .data_we(data_we), .data_size(data_size),
    .data_signed(data_signed), .data_addr(data_addr), .data_wdata(data_wdata),
    .ifetch_done(ifetch_done), .ifetch_rdata(ifetch_rdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .misaligned(misaligned), .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  typedef struct { bit is_data; logic [31:0] rdata; bit mis; } exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; bit we; } bus_t;

  exp_t        sbq[$];
  bus_t        bq[$];
  logic [31:0] slave_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  int          errors = 0, checks = 0;
  int          force_wait = 0;
  logic [31:0] last_data_rdata = 0, last_fetch_rdata = 0;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] wa);
    if (slave_mem.exists(wa)) return slave_mem[wa];
    return init_word(wa);
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] val);
    slave_mem[wa] = val;
    for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = val[8*i +: 8];
  endtask

  task automatic push_data(input bit we, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd);
    int n, lane;
    logic [31:0] v, wdv;
    bus_t b;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    if ((lane % n) != 0) begin
      sbq.push_back('{1'b1, 32'h0, 1'b1});
      return;
    end
    wdv = 0;
    for (int i = 0; i < 4; i++) wdv[8*i +: 8] = wd[8*(i % n) +: 8];
    b.addr = a - 32'(lane);
    b.be = 4'(((1 << n) - 1) << lane);
    b.wd = wdv;
    b.we = we;
    bq.push_back(b);
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      sbq.push_back('{1'b1, 32'h0, 1'b0});
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      sbq.push_back('{1'b1, v, 1'b0});
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    logic [31:0] v;
    if (a[1:0] != 2'b00) begin
      sbq.push_back('{1'b0, 32'h0, 1'b1});
      return;
    end
    bq.push_back('{a, 4'hF, 32'h0, 1'b0});
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    sbq.push_back('{1'b0, v, 1'b0});
  endtask

  // Avalon slave plus bus-cycle checker.
  initial begin
    int wcnt, wait_target;
    bus_t cur;
    logic [31:0] w;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0;
    wcnt = 0; wait_target = 0;
    cur = '{32'h0, 4'h0, 32'h0, 1'b0};
    forever begin
      @(negedge clk);
      if (avm_read || avm_write) begin
        if (wcnt == 0) begin
          wait_target = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bus_cycle: got addr 0x%08h expected no bus cycle", avm_address);
          end else cur = bq.pop_front();
        end
        chk("rw_exclusive", {31'd0, avm_read & avm_write}, 32'd0);
        chk("bus_dir", {31'd0, avm_write}, {31'd0, cur.we});
        chk("bus_addr", avm_address, cur.addr);
        chk("bus_be", {28'd0, avm_byteenable}, {28'd0, cur.be});
        if (cur.we) chk("bus_wdata", avm_writedata, cur.wd);
        avm_waitrequest = (wcnt < wait_target);
        if (!avm_waitrequest) begin
          if (avm_write) begin
            w = slave_rd(avm_address);
            for (int i = 0; i < 4; i++)
              if (avm_byteenable[i]) w[8*i +: 8] = avm_writedata[8*i +: 8];
            slave_mem[avm_address] = w;
          end else avm_readdata = slave_rd(avm_address);
        end
        wcnt++;
      end else begin
        wcnt = 0;
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdata = $urandom;
      end
    end
  end

  // Done monitor: pops the scoreboard whenever a done pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (ifetch_done || data_done)) begin
        chk("done_exclusive", {31'd0, ifetch_done & data_done}, 32'd0);
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with fetch=%0b data=%0b expected none", ifetch_done, data_done);
        end else begin
          e = sbq.pop_front();
          chk("done_src", {31'd0, data_done}, {31'd0, e.is_data});
          chk("rdata", data_done ? data_rdata : ifetch_rdata, e.rdata);
          chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          if (data_done) last_data_rdata = data_rdata;
          else last_fetch_rdata = ifetch_rdata;
        end
      end
    end
  end

  task automatic run_txn(input bit dd, input bit ff, input bit we, input logic [1:0] sz,
                         input bit sg, input logic [31:0] da, input logic [31:0] wd,
                         input logic [31:0] fa, output int lat_d, output int lat_f,
                         output int strobes);
    int cnt;
    bit pd, pf;
    if (dd) push_data(we, sz, sg, da, wd);
    if (ff) push_fetch(fa);
    data_req = dd; data_we = we; data_size = sz; data_signed = sg;
    data_addr = da; data_wdata = wd; ifetch_req = ff; ifetch_addr = fa;
    pd = dd; pf = ff; cnt = 0; lat_d = 0; lat_f = 0; strobes = 0;
    while ((pd || pf) && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (avm_read || avm_write) strobes++;
      if (pd && data_done) begin pd = 0; lat_d = cnt; data_req = 1'b0; end
      if (pf && ifetch_done) begin pf = 0; lat_f = cnt; ifetch_req = 1'b0; end
      if (cnt == 1) begin
        // Fields of an accepted request must be ignored from here on.
        if (dd) begin
          data_we = 1'($urandom); data_size = 2'($urandom); data_signed = 1'($urandom);
          data_addr = $urandom; data_wdata = $urandom;
        end else ifetch_addr = $urandom;
      end
    end
    if (pd || pf) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got pending data=%0b fetch=%0b expected done", pd, pf);
      data_req = 1'b0; ifetch_req = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1);
  end

  function automatic logic [31:0] rand_base();
    case ($urandom_range(0, 2))
      0:       return 32'h0000_1000;
      1:       return 32'hBFC0_0000;
      default: return 32'h8000_2000;
    endcase
  endfunction

  initial begin
    int ld, lf, st;
    int kind;
    logic [31:0] fa;
    reset = 1'b1;
    ifetch_req = 0; ifetch_addr = 0; data_req = 0; data_we = 0;
    data_size = 0; data_signed = 0; data_addr = 0; data_wdata = 0;
    #1;
    chk("reset_ctrl", {26'd0, ifetch_done, data_done, misaligned, busy, avm_read, avm_write}, 32'd0);
    chk("reset_addr", avm_address, 32'd0);
    chk("reset_be_wd", avm_writedata | {28'd0, avm_byteenable}, 32'd0);
    chk("reset_rdata", ifetch_rdata | data_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    force_wait = 0;
    preload(32'hBFC00000, 32'h24020005);
    run_txn(0, 1, 0, 2'd0, 0, 32'h0, 32'h0, 32'hBFC00000, ld, lf, st);
    chk("fetch_latency", 32'(lf), 32'd2);
    chk("fetch_strobes", 32'(st), 32'd1);
    chk("fetch_word", last_fetch_rdata, 32'h24020005);

    preload(32'h00001000, 32'h80FFFFFF);
    run_txn(1, 0, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h0, ld, lf, st);
    chk("lb_value", last_data_rdata, 32'hFFFFFF80);
    chk("lb_latency", 32'(ld), 32'd2);
    run_txn(1, 0, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h0, ld, lf, st);
    chk("lbu_value", last_data_rdata, 32'h00000080);

    force_wait = 3;
    run_txn(1, 0, 1, 2'd1, 0, 32'h2002, 32'h0000BEEF, 32'h0, ld, lf, st);
    chk("sh_latency", 32'(ld), 32'd5);
    chk("sh_strobes", 32'(st), 32'd4);
    force_wait = 0;
    run_txn(1, 0, 0, 2'd1, 0, 32'h2002, 32'h0, 32'h0, ld, lf, st);
    chk("lhu_readback", last_data_rdata, 32'h0000BEEF);

    run_txn(1, 1, 0, 2'd2, 0, 32'h3000, 32'h0, 32'hBFC00000, ld, lf, st);
    chk("arb_data_latency", 32'(ld), 32'd2);
    chk("arb_fetch_latency", 32'(lf), 32'd5);

    run_txn(1, 0, 0, 2'd2, 0, 32'h3001, 32'h0, 32'h0, ld, lf, st);
    chk("mis_latency", 32'(ld), 32'd1);
    chk("mis_strobes", 32'(st), 32'd0);

    // Reset while a fetch is stalled on the bus.
    force_wait = 1000;
    push_fetch(32'hBFC00004);
    ifetch_addr = 32'hBFC00004;
    ifetch_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("bus_held_read", {31'd0, avm_read}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("reset_drop", {28'd0, avm_read, avm_write, busy, ifetch_done}, 32'd0);
    ifetch_req = 1'b0;
    sbq.delete();
    bq.delete();
    @(negedge clk);
    reset = 1'b0;
    force_wait = 0;
    @(negedge clk);
    run_txn(0, 1, 0, 2'd0, 0, 32'h0, 32'h0, 32'hBFC00000, ld, lf, st);
    chk("post_reset_fetch", last_fetch_rdata, 32'h24020005);
    chk("post_reset_latency", 32'(lf), 32'd2);

    force_wait = -1;
    repeat (300) begin
      kind = int'($urandom_range(0, 2));
      fa = rand_base() + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) fa = fa + 32'($urandom_range(1, 3));
      run_txn(kind != 0, kind != 1, 1'($urandom), 2'($urandom), 1'($urandom),
              rand_base() + 32'($urandom_range(0, 63)), $urandom, fa, ld, lf, st);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    chk("bus_queue_empty", 32'(bq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
